muldiv_unit: RTL and testbench

- Iterative multiply/divide execution unit that sits directly downstream of the instruction control unit.
- Consumes the 5-bit ALUCtrl code together with both register operands for the RV32M operations: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU.
- Holds the pipeline with a stall output while it iterates, then returns a registered result with a one-cycle done pulse.
- The main ALU executes all other ALUCtrl codes; this block ignores them.

---
 rtl/muldiv_unit.sv | 231 +++++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit placed after the
// instruction control unit. It takes an ALUCtrl code and two operands, holds
// the pipeline through stall while it iterates, and then returns a registered
// result with a one-cycle done pulse.
//
// Optional build macro: MULDIV_FAST_MUL_EN
//   defined   - the four multiplies finish in one cycle using a 2*BITS wide
//               combinational product. Divides still iterate.
//   undefined - every operation iterates BITS shift-add or shift-subtract
//               steps, so no wide multiplier is built.
//
// Handshake: the request is qualified by start in the cycle the operands are
// presented. It is accepted when the unit is not BUSY, flush is low and
// alu_ctrl is an M code. stall is high while BUSY and in any accepting cycle.
// done is high for exactly one cycle (DONE). result holds between pulses.

package muldiv_pkg;
    localparam logic [4:0] ALUCTRL_ADD    = 5'h00;
    localparam logic [4:0] ALUCTRL_SUB    = 5'h01;
    localparam logic [4:0] ALUCTRL_AND    = 5'h02;
    localparam logic [4:0] ALUCTRL_OR     = 5'h03;
    localparam logic [4:0] ALUCTRL_XOR    = 5'h04;
    localparam logic [4:0] ALUCTRL_SLL    = 5'h05;
    localparam logic [4:0] ALUCTRL_SRL    = 5'h06;
    localparam logic [4:0] ALUCTRL_SRA    = 5'h07;
    localparam logic [4:0] ALUCTRL_SLT    = 5'h08;
    localparam logic [4:0] ALUCTRL_SLTU   = 5'h09;
    localparam logic [4:0] ALUCTRL_MUL    = 5'h10;
    localparam logic [4:0] ALUCTRL_MULH   = 5'h11;
    localparam logic [4:0] ALUCTRL_MULHSU = 5'h12;
    localparam logic [4:0] ALUCTRL_MULHU  = 5'h13;
    localparam logic [4:0] ALUCTRL_DIV    = 5'h14;
    localparam logic [4:0] ALUCTRL_DIVU   = 5'h15;
    localparam logic [4:0] ALUCTRL_REM    = 5'h16;
    localparam logic [4:0] ALUCTRL_REMU   = 5'h17;
endpackage

module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int BITS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [4:0]      alu_ctrl,
    input  logic [BITS-1:0] op_a,
    input  logic [BITS-1:0] op_b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [BITS-1:0] result,
    output logic            stall
);

    localparam int CW = $clog2(BITS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       count_q, count_d;
    logic [4:0]          op_q, op_d;
    logic                neg_q, neg_d;
    logic                early_q, early_d;
    logic                fast_q, fast_d;
    logic [2*BITS-1:0]   prod_q, prod_d;    // {hi, lo}: product or {remainder, quotient}
    logic [BITS-1:0]     mcand_q, mcand_d;  // multiplicand or divisor magnitude
    logic [BITS-1:0]     result_q, result_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    // Request decode: operand magnitudes, sign of the final result and early-out cases
    logic                is_m, is_div, sgn_a, sgn_b, a_neg, b_neg, res_neg;
    logic                div_zero, div_ovf, early, accept;
    logic [BITS-1:0]     mag_a, mag_b, early_res;

    always_comb begin
        is_m     = alu_ctrl inside {ALUCTRL_MUL, ALUCTRL_MULH, ALUCTRL_MULHSU, ALUCTRL_MULHU,
                                    ALUCTRL_DIV, ALUCTRL_DIVU, ALUCTRL_REM, ALUCTRL_REMU};
        is_div   = alu_ctrl inside {ALUCTRL_DIV, ALUCTRL_DIVU, ALUCTRL_REM, ALUCTRL_REMU};
        sgn_a    = alu_ctrl inside {ALUCTRL_MUL, ALUCTRL_MULH, ALUCTRL_MULHSU, ALUCTRL_DIV, ALUCTRL_REM};
        sgn_b    = alu_ctrl inside {ALUCTRL_MUL, ALUCTRL_MULH, ALUCTRL_DIV, ALUCTRL_REM};
        a_neg    = sgn_a & op_a[BITS-1];
        b_neg    = sgn_b & op_b[BITS-1];
        mag_a    = a_neg ? -op_a : op_a;
        mag_b    = b_neg ? -op_b : op_b;
        // A remainder takes the dividend's sign; everything else takes the product of signs
        res_neg  = (alu_ctrl == ALUCTRL_REM) ? a_neg : (a_neg ^ b_neg);
        div_zero = is_div & (op_b == '0);
        div_ovf  = (alu_ctrl inside {ALUCTRL_DIV, ALUCTRL_REM}) &
                   (op_a == {1'b1, {(BITS-1){1'b0}}}) & (&op_b);
        early    = div_zero | div_ovf;
        early_res = '0;
        if (div_zero) begin
            early_res = (alu_ctrl inside {ALUCTRL_DIV, ALUCTRL_DIVU}) ? '1 : op_a;
        end else if (div_ovf) begin
            early_res = (alu_ctrl == ALUCTRL_DIV) ? op_a : '0;
        end
        accept   = start & ~flush & is_m & (state_q != BUSY);
        stall    = (state_q == BUSY) | accept;
    end

    // One iteration step plus the final sign fix-up and result selection
    logic [BITS:0]       mul_sum, div_shift;
    logic [BITS-1:0]     div_diff, div_rem;
    logic                div_take;
    logic [2*BITS-1:0]   step_val, fin_prod, mul_full;
    logic [BITS-1:0]     quo_mag, rem_mag, fin_res;

    always_comb begin
        if (op_q inside {ALUCTRL_DIV, ALUCTRL_DIVU, ALUCTRL_REM, ALUCTRL_REMU}) begin
            // Restoring divide: shift the next dividend bit in, subtract if it fits
            div_shift = {prod_q[2*BITS-1:BITS], prod_q[BITS-1]};
            div_take  = (div_shift >= {1'b0, mcand_q});
            div_diff  = div_shift[BITS-1:0] - mcand_q;
            div_rem   = div_take ? div_diff : div_shift[BITS-1:0];
            step_val  = {div_rem, prod_q[BITS-2:0], div_take};
            mul_sum   = '0;
        end else begin
            // Shift-add multiply: multiplier sits in the low half and is consumed LSB first
            div_shift = '0;
            div_take  = 1'b0;
            div_diff  = '0;
            div_rem   = '0;
            mul_sum   = {1'b0, prod_q[2*BITS-1:BITS]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
            step_val  = {mul_sum, prod_q[BITS-1:1]};
        end
`ifdef MULDIV_FAST_MUL_EN
        fin_prod = fast_q ? ({{BITS{1'b0}}, mcand_q} * {{BITS{1'b0}}, prod_q[BITS-1:0]}) : step_val;
`else
        fin_prod = step_val;
`endif
        mul_full = neg_q ? -fin_prod : fin_prod;
        quo_mag  = fin_prod[BITS-1:0];
        rem_mag  = fin_prod[2*BITS-1:BITS];
        case (op_q)
            ALUCTRL_MUL:                                    fin_res = mul_full[BITS-1:0];
            ALUCTRL_MULH, ALUCTRL_MULHSU, ALUCTRL_MULHU:    fin_res = mul_full[2*BITS-1:BITS];
            ALUCTRL_DIV, ALUCTRL_DIVU:                      fin_res = neg_q ? -quo_mag : quo_mag;
            ALUCTRL_REM, ALUCTRL_REMU:                      fin_res = neg_q ? -rem_mag : rem_mag;
            default:                                        fin_res = '0;
        endcase
    end

    // Next-state logic: iterate in BUSY, flush aborts, accept loads a new operation
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        op_d     = op_q;
        neg_d    = neg_q;
        early_d  = early_q;
        fast_d   = fast_q;
        prod_d   = prod_q;
        mcand_d  = mcand_q;
        result_d = result_q;
        case (state_q)
            IDLE: ;
            BUSY: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (early_q) begin
                    result_d = prod_q[BITS-1:0];
                    state_d  = DONE;
                end else if (fast_q || (count_q == CW'(BITS-1))) begin
                    result_d = fin_res;
                    state_d  = DONE;
                end else begin
                    prod_d  = step_val;
                    count_d = count_q + CW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (accept) begin
            state_d = BUSY;
            count_d = '0;
            op_d    = alu_ctrl;
            neg_d   = res_neg;
            early_d = early;
`ifdef MULDIV_FAST_MUL_EN
            fast_d  = ~is_div;
`else
            fast_d  = 1'b0;
`endif
            mcand_d = is_div ? mag_b : mag_a;
            prod_d  = early  ? {{BITS{1'b0}}, early_res} :
                      is_div ? {{BITS{1'b0}}, mag_a} : {{BITS{1'b0}}, mag_b};
        end
        busy_d = (state_d == BUSY);
        done_d = (state_d == DONE);
    end

    // State and datapath registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            early_q  <= 1'b0;
            fast_q   <= 1'b0;
            prod_q   <= '0;
            mcand_q  <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            early_q  <= early_d;
            fast_q   <= fast_d;
            prod_q   <= prod_d;
            mcand_q  <= mcand_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed vectors with literal expectations, and an
// arithmetic reference model that predicts each result and its done cycle.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int BITS    = 32;
    localparam int TIMEOUT = 200;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            flush = 1'b0;
    logic [4:0]      alu_ctrl = '0;
    logic [BITS-1:0] op_a = '0;
    logic [BITS-1:0] op_b = '0;
    logic            busy, done, stall;
    logic [BITS-1:0] result;

    muldiv_unit #(.BITS(BITS)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .alu_ctrl(alu_ctrl),
        .op_a(op_a), .op_b(op_b), .flush(flush),
        .busy(busy), .done(done), .result(result), .stall(stall)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    logic [BITS-1:0] exp_q[$];
    int              exp_t_q[$];
    logic [BITS-1:0] model_res = '0;

    task automatic check(input string name, input logic [BITS-1:0] act, input logic [BITS-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: RV32M results from plain 64-bit arithmetic
    function automatic logic [BITS-1:0] model(input logic [4:0] c, input logic [BITS-1:0] a, input logic [BITS-1:0] b);
        longint sa, sb, ub;
        longint unsigned uu;
        logic [63:0] p;
        logic ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ub  = longint'({32'b0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = '0;
        case (c)
            ALUCTRL_MUL:    begin p = sa * sb; return p[31:0]; end
            ALUCTRL_MULH:   begin p = sa * sb; return p[63:32]; end
            ALUCTRL_MULHSU: begin p = sa * ub; return p[63:32]; end
            ALUCTRL_MULHU:  begin uu = {32'b0, a}; uu = uu * {32'b0, b}; p = uu; return p[63:32]; end
            ALUCTRL_DIV:    begin if (b == 0) return '1; if (ovf) return a; p = sa / sb; return p[31:0]; end
            ALUCTRL_DIVU:   begin if (b == 0) return '1; return a / b; end
            ALUCTRL_REM:    begin if (b == 0) return a; if (ovf) return '0; p = sa % sb; return p[31:0]; end
            ALUCTRL_REMU:   begin if (b == 0) return a; return a % b; end
            default:        return '0;
        endcase
    endfunction

    function automatic int latency(input logic [4:0] c, input logic [BITS-1:0] a, input logic [BITS-1:0] b);
        if (c inside {ALUCTRL_MUL, ALUCTRL_MULH, ALUCTRL_MULHSU, ALUCTRL_MULHU}) begin
`ifdef MULDIV_FAST_MUL_EN
            return 1;
`else
            return BITS;
`endif
        end
        if (b == 0) return 1;
        if ((c == ALUCTRL_DIV || c == ALUCTRL_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return BITS;
    endfunction

    // scoreboard compare: done timing, result at done, result hold otherwise
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_done: got done=1 expected done=0 (cycle %0d)", cyc);
                end else begin
                    check("done_cycle", cyc, exp_t_q[0]);
                    check("result_at_done", result, exp_q[0]);
                    model_res = exp_q.pop_front();
                    void'(exp_t_q.pop_front());
                end
            end else if (exp_t_q.size() > 0 && cyc >= exp_t_q[0]) begin
                checks++; failures++;
                $display("FAIL missing_done: got done=0 expected done=1 at cycle %0d", exp_t_q[0]);
                void'(exp_q.pop_front());
                void'(exp_t_q.pop_front());
            end
            check("result_hold", result, model_res);
        end
    end

    // driver: call at a negedge; returns just after the accepting edge
    task automatic issue(input logic [4:0] c, input logic [BITS-1:0] a, input logic [BITS-1:0] b);
        start = 1'b1; alu_ctrl = c; op_a = a; op_b = b;
        #1;
        check("stall_on_issue", stall, 1'b1);
        exp_q.push_back(model(c, a, b));
        exp_t_q.push_back(cyc + 1 + latency(c, a, b));
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_accept", busy, 1'b1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < TIMEOUT && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            checks++; failures++;
            $display("FAIL wait_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
            exp_t_q.delete();
        end
    endtask

    typedef struct {
        logic [4:0]      c;
        logic [BITS-1:0] a;
        logic [BITS-1:0] b;
        logic [BITS-1:0] r;
    } vec_t;

    vec_t vecs[16] = '{
        '{ALUCTRL_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB},
        '{ALUCTRL_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000},
        '{ALUCTRL_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE},
        '{ALUCTRL_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF},
        '{ALUCTRL_MULH,   32'h7FFF_FFFF,  32'h7FFF_FFFF, 32'h3FFF_FFFF},
        '{ALUCTRL_MULHU,  32'h8000_0000,  32'd2,         32'd1},
        '{ALUCTRL_DIV,    32'hFFFF_FFEC,  32'd6,         32'hFFFF_FFFD},
        '{ALUCTRL_REM,    32'hFFFF_FFEC,  32'd6,         32'hFFFF_FFFE},
        '{ALUCTRL_DIVU,   32'd20,         32'd6,         32'd3},
        '{ALUCTRL_REMU,   32'd20,         32'd6,         32'd2},
        '{ALUCTRL_DIV,    32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD},
        '{ALUCTRL_REM,    32'd7,          32'hFFFF_FFFE, 32'd1},
        '{ALUCTRL_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000},
        '{ALUCTRL_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0},
        '{ALUCTRL_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF},
        '{ALUCTRL_REM,    32'd5,          32'd0,         32'd5}
    };

    initial begin
        // reset state
        #1;
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_result", result, '0);
        check("reset_stall", stall, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // directed vectors
        foreach (vecs[i]) begin
            check("model_pin", model(vecs[i].c, vecs[i].a, vecs[i].b), vecs[i].r);
            @(negedge clk);
            issue(vecs[i].c, vecs[i].a, vecs[i].b);
            wait_idle();
            check("vec_result", result, vecs[i].r);
        end

        // non-M code is ignored
        @(negedge clk);
        start = 1'b1; alu_ctrl = ALUCTRL_ADD; op_a = 32'd1; op_b = 32'd2;
        #1;
        check("add_stall", stall, 1'b0);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("add_busy", busy, 1'b0);
        repeat (3) @(negedge clk);

        // start while BUSY is ignored
        @(negedge clk);
        issue(ALUCTRL_DIVU, 32'd100, 32'd7);
        repeat (3) @(negedge clk);
        start = 1'b1; alu_ctrl = ALUCTRL_DIV; op_a = 32'd50; op_b = 32'd5;
        #1;
        check("busy_stall", stall, 1'b1);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle();
        check("busy_ignore_result", result, 32'd14);

        // back-to-back issue in the DONE cycle
        @(negedge clk);
        issue(ALUCTRL_DIVU, 32'd1000, 32'd7);
        for (int i = 0; i < TIMEOUT; i++) begin
            @(negedge clk);
            if (done) break;
        end
        check("b2b_first_done", done, 1'b1);
        issue(ALUCTRL_DIVU, 32'd99, 32'd10);
        wait_idle();
        check("b2b_result", result, 32'd9);

        // flush mid-BUSY
        @(negedge clk);
        issue(ALUCTRL_DIV, 32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        exp_q.delete();
        exp_t_q.delete();
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_busy", busy, 1'b0);
        check("flush_done", done, 1'b0);
        repeat (40) @(negedge clk);
        check("flush_result_kept", result, 32'd9);

        // reset mid-BUSY
        @(negedge clk);
        issue(ALUCTRL_REMU, 32'd12345, 32'd100);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        exp_t_q.delete();
        model_res = '0;
        #1;
        check("arst_busy", busy, 1'b0);
        check("arst_result", result, '0);
        check("arst_done", done, 1'b0);
        check("arst_stall", stall, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);

        // unit still works after reset
        issue(ALUCTRL_MUL, 32'd1234, 32'd5678);
        wait_idle();
        check("post_reset_mul", result, 32'd7006652);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
